palette_video_out: RTL

- Parametrised pixel output stage for the graphics pipeline, replacing the fixed four-colour case statement.
- Converts the per-pixel colour code into VGA RGB through CPU-programmable palette registers. Those registers are double-buffered and swapped at vertical sync, so there is no mid-frame tearing.
- Delays HS/VS/BLANK_N so they stay aligned with the pixel data.
- Sits between pixelLookup/computeTile/vga and the DAC pins, and shares the CPU bus with the playfield RAM and motion objects.

---
 rtl/palette_video_out.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/palette_video_out.sv
// palette_video_out: pixel output stage. Maps per-pixel colour codes to VGA RGB
// through CPU-programmable, double-buffered palette registers that swap at the
// falling edge of vertical sync. Syncs and blank are delayed to stay aligned
// with the colour data.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   cs_l, we_l          bus chip select / write enable, active low
//   addr, data_in       bus address and write data
//   data_out            bus read data (combinational)
//   color_code          pixel colour code (CODE_W bits)
//   pixel_blank         1 = border pixel (outside playfield)
//   hs_in, vs_in        syncs from the vga block, active low
//   blank_n_in          0 = retrace
//   VGA_R/G/B           colour outputs, CHAN_W bits each
//   VGA_HS/VS/BLANK_N   delayed syncs and blank
//   frame_swap          one-cycle pulse when the active palette is reloaded
module palette_video_out #(
    parameter int unsigned CODE_W     = 2,
    parameter int unsigned CHAN_W     = 8,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter logic [15:0] PAL_BASE   = 16'h1404
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_l,
    input  logic              we_l,
    input  logic [15:0]       addr,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    input  logic [CODE_W-1:0] color_code,
    input  logic              pixel_blank,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              blank_n_in,
    output logic [CHAN_W-1:0] VGA_R,
    output logic [CHAN_W-1:0] VGA_G,
    output logic [CHAN_W-1:0] VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              frame_swap
);

    localparam int unsigned ENTRIES    = 2 ** CODE_W;
    // Number of registered stages from stage 2 up to the outputs.
    localparam int unsigned DLY        = PIPE_DEPTH - 1;
    localparam logic [15:0] CTRL_OFS   = 16'(ENTRIES);
    localparam logic [15:0] BORDER_OFS = 16'(ENTRIES + 1);

    // Replicate a 3-bit field MSB-first across the channel width.
    function automatic logic [CHAN_W-1:0] expand3(input logic [2:0] f);
        logic [CHAN_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CHAN_W); i++) begin
            r[int'(CHAN_W) - 1 - i] = f[2 - (i % 3)];
        end
        return r;
    endfunction

    // Replicate a 2-bit field MSB-first across the channel width.
    function automatic logic [CHAN_W-1:0] expand2(input logic [1:0] f);
        logic [CHAN_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CHAN_W); i++) begin
            r[int'(CHAN_W) - 1 - i] = f[1 - (i % 2)];
        end
        return r;
    endfunction

    logic [7:0]        shadow [ENTRIES];
    logic [7:0]        active [ENTRIES];
    logic [1:0]        ctrl;
    logic [7:0]        border;
    logic              vs_q;

    logic [15:0]       ofs;
    logic [CODE_W-1:0] idx;
    logic              hit_pal;
    logic              hit_ctrl;
    logic              hit_border;
    logic              wr_c;
    logic              swap_c;

    // Address decode relative to the palette base.
    assign ofs        = addr - PAL_BASE;
    assign idx        = ofs[CODE_W-1:0];
    assign hit_pal    = (ofs < CTRL_OFS);
    assign hit_ctrl   = (ofs == CTRL_OFS);
    assign hit_border = (ofs == BORDER_OFS);
    assign wr_c       = ~cs_l & ~we_l;
    assign swap_c     = vs_q & ~vs_in;

    // Register file: shadow/active palette, CTRL, BORDER, vsync edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            ctrl       <= '0;
            border     <= '0;
            vs_q       <= 1'b1;
            frame_swap <= 1'b0;
        end else begin
            vs_q       <= vs_in;
            frame_swap <= swap_c;
            // Swap copies the pre-write shadow; a coincident write lands next frame.
            if (swap_c) begin
                for (int i = 0; i < int'(ENTRIES); i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_c && hit_pal) begin
                shadow[idx] <= data_in;
                // Immediate mode also updates the live entry (overrides the swap copy).
                if (ctrl[0]) begin
                    active[idx] <= data_in;
                end
            end
            if (wr_c && hit_ctrl) begin
                ctrl <= data_in[1:0];
            end
            if (wr_c && hit_border) begin
                border <= data_in;
            end
        end
    end

    // Bus readback.
    always_comb begin
        data_out = 8'h00;
        if (!cs_l) begin
            if (hit_pal) begin
                data_out = shadow[idx];
            end else if (hit_ctrl) begin
                data_out = {6'b0, ctrl};
            end else if (hit_border) begin
                data_out = border;
            end
        end
    end

    // Stage 1: capture pixel inputs.
    logic [CODE_W-1:0] s1_code;
    logic              s1_pb;
    logic              s1_hs;
    logic              s1_vs;
    logic              s1_bn;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_code <= '0;
            s1_pb   <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_bn   <= 1'b0;
        end else begin
            s1_code <= color_code;
            s1_pb   <= pixel_blank;
            s1_hs   <= hs_in;
            s1_vs   <= vs_in;
            s1_bn   <= blank_n_in;
        end
    end

    // Stage 2 colour select: retrace/force-black, then border, then palette.
    logic [7:0]        entry_c;
    logic              black_c;
    logic [CHAN_W-1:0] r_c;
    logic [CHAN_W-1:0] g_c;
    logic [CHAN_W-1:0] b_c;

    always_comb begin
        entry_c = s1_pb ? border : active[s1_code];
        black_c = ~s1_bn | ctrl[1];
        r_c     = expand3(entry_c[7:5]);
        g_c     = expand3(entry_c[4:2]);
        b_c     = expand2(entry_c[1:0]);
        if (black_c) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end
    end

    // Stage 2 register followed by pure delay stages; index DLY-1 drives the pins.
    logic [CHAN_W-1:0] r_d [DLY];
    logic [CHAN_W-1:0] g_d [DLY];
    logic [CHAN_W-1:0] b_d [DLY];
    logic [DLY-1:0]    hs_d;
    logic [DLY-1:0]    vs_d;
    logic [DLY-1:0]    bn_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DLY); i++) begin
                r_d[i]  <= '0;
                g_d[i]  <= '0;
                b_d[i]  <= '0;
                hs_d[i] <= 1'b1;
                vs_d[i] <= 1'b1;
                bn_d[i] <= 1'b0;
            end
        end else begin
            r_d[0]  <= r_c;
            g_d[0]  <= g_c;
            b_d[0]  <= b_c;
            hs_d[0] <= s1_hs;
            vs_d[0] <= s1_vs;
            bn_d[0] <= s1_bn;
            for (int i = 1; i < int'(DLY); i++) begin
                r_d[i]  <= r_d[i-1];
                g_d[i]  <= g_d[i-1];
                b_d[i]  <= b_d[i-1];
                hs_d[i] <= hs_d[i-1];
                vs_d[i] <= vs_d[i-1];
                bn_d[i] <= bn_d[i-1];
            end
        end
    end

    assign VGA_R       = r_d[DLY-1];
    assign VGA_G       = g_d[DLY-1];
    assign VGA_B       = b_d[DLY-1];
    assign VGA_HS      = hs_d[DLY-1];
    assign VGA_VS      = vs_d[DLY-1];
    assign VGA_BLANK_N = bn_d[DLY-1];

endmodule
